program_loader: RTL and testbench

- Boot-time loader sitting directly upstream of the instruction fetch stage.
- Accepts a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Writes the words into instruction memory starting at word address 0.
- Holds the processor in reset until a frame has loaded and its checksum has verified.

---
 rtl/loader_pkg.sv | 24 ++
 rtl/byte_to_word_assembler.sv | 36 +++
 rtl/program_loader.sv | 136 +++++++++++++
 tb/tb_program_loader.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and widths for the boot-time program loader.
// The state set is shared by the loader FSM and its byte-acceptance decode.
package loader_pkg;

    localparam int BYTE_WIDTH = 8;
    localparam int WORD_WIDTH = 32;
    localparam int CNT_WIDTH  = 16;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CHECK,
        DONE,
        ERROR
    } state_t;

    // Bytes are taken from the stream only while a frame is being parsed.
    function automatic logic accepts_bytes(input state_t s);
        return (s == LEN_HI) || (s == LEN_LO) || (s == DATA) || (s == CHECK);
    endfunction

endpackage

// File: rtl/byte_to_word_assembler.sv
// Packs four consecutive stream bytes into one big-endian 32-bit word.
// word_valid and word are combinational and valid on the cycle the 4th byte is taken.
module byte_to_word_assembler
    import loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  byte_en,
    input  logic [BYTE_WIDTH-1:0] byte_in,
    output logic                  word_valid,
    output logic [WORD_WIDTH-1:0] word
);

    logic [1:0]            byte_cnt;
    logic [WORD_WIDTH-1:0] shift_reg;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt  <= '0;
            shift_reg <= '0;
        end else if (clear) begin
            byte_cnt  <= '0;
            shift_reg <= '0;
        end else if (byte_en) begin
            byte_cnt  <= byte_cnt + 2'd1;
            shift_reg <= {shift_reg[WORD_WIDTH-BYTE_WIDTH-1:0], byte_in};
        end
    end

    assign word_valid = byte_en && (byte_cnt == 2'd3);
    assign word       = {shift_reg[WORD_WIDTH-BYTE_WIDTH-1:0], byte_in};

endmodule

// File: rtl/program_loader.sv
// Boot loader: parses a length-prefixed byte frame, writes words to instruction
// memory from address 0, verifies an XOR checksum and then releases cpu_reset.
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  start,
    input  logic [BYTE_WIDTH-1:0] byte_data,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [WORD_WIDTH-1:0] imem_wdata,
    output logic                  cpu_reset,
    output logic                  load_done,
    output logic                  load_error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam logic [CNT_WIDTH:0] CAPACITY = (CNT_WIDTH + 1)'(1) << ADDR_WIDTH;

    state_t                state;
    logic [BYTE_WIDTH-1:0] len_hi;
    logic [BYTE_WIDTH-1:0] csum;
    logic [CNT_WIDTH-1:0]  words_left;
    logic [CNT_WIDTH-1:0]  frame_len;
    logic                  accept;
    logic                  asm_en;
    logic                  asm_clear;
    logic                  word_valid;
    logic [WORD_WIDTH-1:0] word;

    assign byte_ready = accepts_bytes(state);
    assign accept     = byte_valid && byte_ready;
    assign asm_en     = accept && (state == DATA);
    assign asm_clear  = start && ((state == IDLE) || (state == DONE) || (state == ERROR));
    assign frame_len  = {len_hi, byte_data};

    byte_to_word_assembler u_assembler (
        .clk        (CLK),
        .rst        (RESET),
        .clear      (asm_clear),
        .byte_en    (asm_en),
        .byte_in    (byte_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state        <= IDLE;
            len_hi       <= '0;
            csum         <= '0;
            words_left   <= '0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            cpu_reset    <= 1'b1;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
            words_loaded <= '0;
        end else begin
            // The write pulse follows the 4th byte; the address advances once it retires.
            imem_we <= word_valid;
            if (word_valid) begin
                imem_wdata <= word;
            end
            if (imem_we) begin
                imem_addr    <= imem_addr + ADDR_WIDTH'(1);
                words_loaded <= words_loaded + (ADDR_WIDTH + 1)'(1);
            end

            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state        <= LEN_HI;
                        csum         <= '0;
                        imem_addr    <= '0;
                        words_loaded <= '0;
                        load_done    <= 1'b0;
                        load_error   <= 1'b0;
                        cpu_reset    <= 1'b1;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        len_hi <= byte_data;
                        state  <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        words_left <= frame_len;
                        if ({1'b0, frame_len} > CAPACITY) begin
                            state      <= ERROR;
                            load_error <= 1'b1;
                        end else if (frame_len == '0) begin
                            state <= CHECK;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        csum <= csum ^ byte_data;
                        if (word_valid) begin
                            words_left <= words_left - CNT_WIDTH'(1);
                            // Leave DATA as the last word completes so the very next byte is the checksum.
                            if (words_left == CNT_WIDTH'(1)) begin
                                state <= CHECK;
                            end
                        end
                    end
                end
                CHECK: begin
                    if (accept) begin
                        if (byte_data == csum) begin
                            state     <= DONE;
                            load_done <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            state      <= ERROR;
                            load_error <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: a frame-position reference model checked
// every cycle, plus directed frames with hand-computed expectations.
module tb_program_loader;

    localparam int AW  = 8;
    localparam int CAP = 1 << AW;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    byte_data = '0;
    logic          byte_valid = 1'b0;
    logic          byte_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_reset;
    logic          load_done;
    logic          load_error;
    logic [AW:0]   words_loaded;

    program_loader #(.ADDR_WIDTH(AW)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .start        (start),
        .byte_data    (byte_data),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_reset    (cpu_reset),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the position of each accepted byte within the frame.
    bit          m_busy = 0;
    int          m_pos = 0;
    int          m_len = 0;
    bit [7:0]    m_hi = 0;
    bit [7:0]    m_csum = 0;
    bit [31:0]   m_acc = 0;
    bit          m_we = 0;
    bit [31:0]   m_wdata = 0;
    logic [AW:0] m_writes_done = '0;
    bit          m_done = 0;
    bit          m_err = 0;
    bit          m_cpu_reset = 1;

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            m_busy = 0; m_pos = 0; m_len = 0; m_hi = 0; m_csum = 0; m_acc = 0;
            m_we = 0; m_wdata = 0; m_writes_done = '0;
            m_done = 0; m_err = 0; m_cpu_reset = 1;
        end else begin
            if (m_we) m_writes_done = m_writes_done + 1'b1;
            m_we = 0;
            if (start && !m_busy) begin
                m_busy = 1; m_pos = 0; m_csum = 0; m_acc = 0; m_writes_done = '0;
                m_done = 0; m_err = 0; m_cpu_reset = 1;
            end else if (m_busy && byte_valid) begin
                if (m_pos == 0) begin
                    m_hi = byte_data;
                end else if (m_pos == 1) begin
                    m_len = {m_hi, byte_data};
                    if (m_len > CAP) begin
                        m_busy = 0;
                        m_err  = 1;
                    end
                end else if (m_pos < 2 + 4 * m_len) begin
                    m_csum ^= byte_data;
                    m_acc = {m_acc[23:0], byte_data};
                    if ((m_pos - 2) % 4 == 3) begin
                        m_we    = 1;
                        m_wdata = m_acc;
                    end
                end else begin
                    if (byte_data == m_csum) begin
                        m_done      = 1;
                        m_cpu_reset = 0;
                    end else begin
                        m_err = 1;
                    end
                    m_busy = 0;
                end
                m_pos++;
            end
        end
    end

    // Observed write log for the directed checks.
    logic [AW-1:0] log_addr[$];
    logic [31:0]   log_data[$];

    always @(negedge CLK) begin
        check("byte_ready", byte_ready, m_busy);
        check("imem_we", imem_we, m_we);
        check("imem_addr", imem_addr, m_writes_done[AW-1:0]);
        check("imem_wdata", imem_wdata, m_wdata);
        check("cpu_reset", cpu_reset, m_cpu_reset);
        check("load_done", load_done, m_done);
        check("load_error", load_error, m_err);
        check("words_loaded", words_loaded, m_writes_done);
        if (imem_we) begin
            log_addr.push_back(imem_addr);
            log_data.push_back(imem_wdata);
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
    endtask

    // Sends every byte of q, inserting random idle cycles; optionally pulses start on byte 6.
    task automatic send_bytes(input logic [7:0] q[$], input int gap_pct, input bit mid_start);
        logic r;
        int   t;
        foreach (q[i]) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                byte_valid = 1'b0;
                byte_data  = 8'($urandom);
                @(posedge CLK); #1;
            end
            byte_valid = 1'b1;
            byte_data  = q[i];
            start      = mid_start && (i == 6);
            t = 0;
            do begin
                @(negedge CLK);
                r = byte_ready;
                @(posedge CLK); #1;
                start = 1'b0;
                t++;
            end while (!r && t < 100);
            if (!r) begin
                check("accept_timeout", 1'b0, 1'b1);
                byte_valid = 1'b0;
                return;
            end
        end
        byte_valid = 1'b0;
    endtask

    task automatic make_frame(input logic [31:0] w[$], input bit bad, output logic [7:0] f[$]);
        logic [7:0] cs;
        f  = {};
        cs = 8'h00;
        f.push_back(8'(w.size() >> 8));
        f.push_back(8'(w.size()));
        foreach (w[i]) begin
            for (int b = 3; b >= 0; b--) begin
                f.push_back(w[i][b*8 +: 8]);
                cs ^= w[i][b*8 +: 8];
            end
        end
        f.push_back(bad ? (cs ^ 8'h5A) : cs);
    endtask

    task automatic random_words(input int n, output logic [31:0] w[$]);
        w = {};
        for (int i = 0; i < n; i++) w.push_back($urandom);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_byte_ready"}, byte_ready, 1'b0);
        check({tag, "_imem_we"}, imem_we, 1'b0);
        check({tag, "_imem_addr"}, imem_addr, '0);
        check({tag, "_imem_wdata"}, imem_wdata, '0);
        check({tag, "_cpu_reset"}, cpu_reset, 1'b1);
        check({tag, "_load_done"}, load_done, 1'b0);
        check({tag, "_load_error"}, load_error, 1'b0);
        check({tag, "_words_loaded"}, words_loaded, '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  f[$];
        logic [7:0]  part[$];
        logic [31:0] w[$];
        logic [31:0] w2[$];
        int          base;
        int          base2;
        int          n;
        bit          bad;

        repeat (3) @(posedge CLK);
        #1;
        check_reset_values("reset");
        RESET = 1'b0;
        @(posedge CLK); #1;

        // Nominal 2-word frame; checksum is the XOR of the eight data bytes = 0xAC.
        pulse_start();
        base = log_addr.size();
        f = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04, 8'hAC};
        send_bytes(f, 0, 0);
        check("nom_cpu_reset_low", cpu_reset, 1'b0);
        check("nom_load_done", load_done, 1'b1);
        check("nom_words_loaded", words_loaded, 9'd2);
        check("nom_write_count", log_addr.size() - base, 2);
        if (log_addr.size() - base == 2) begin
            check("nom_addr0", log_addr[base], 8'd0);
            check("nom_data0", log_data[base], 32'h2008_0005);
            check("nom_addr1", log_addr[base+1], 8'd1);
            check("nom_data1", log_data[base+1], 32'h8C09_0004);
        end

        // Same frame with a wrong checksum.
        pulse_start();
        base = log_addr.size();
        f[10] = 8'h00;
        send_bytes(f, 0, 0);
        check("bad_load_error", load_error, 1'b1);
        check("bad_load_done", load_done, 1'b0);
        check("bad_cpu_reset", cpu_reset, 1'b1);
        check("bad_write_count", log_addr.size() - base, 2);

        // Zero-length frame.
        pulse_start();
        base = log_addr.size();
        f = '{8'h00, 8'h00, 8'h00};
        send_bytes(f, 0, 0);
        repeat (2) @(posedge CLK);
        #1;
        check("zero_no_writes", log_addr.size() - base, 0);
        check("zero_load_done", load_done, 1'b1);

        // Oversize frame: 0x0101 words exceeds the 256-word memory.
        pulse_start();
        f = '{8'h01, 8'h01};
        send_bytes(f, 0, 0);
        check("over_load_error", load_error, 1'b1);
        byte_valid = 1'b1;
        byte_data  = 8'h33;
        repeat (3) begin
            @(negedge CLK);
            check("over_byte_ready", byte_ready, 1'b0);
        end
        @(posedge CLK); #1;
        byte_valid = 1'b0;

        // 4-word frame gap-free, then with random gaps and a mid-DATA start pulse.
        random_words(4, w);
        make_frame(w, 0, f);
        pulse_start();
        base = log_addr.size();
        send_bytes(f, 0, 0);
        pulse_start();
        base2 = log_addr.size();
        send_bytes(f, 50, 1);
        check("gap_load_done", load_done, 1'b1);
        check("gap_write_count", log_addr.size() - base2, 4);
        for (int i = 0; i < 4 && base2 + i < log_addr.size(); i++) begin
            check("gap_same_addr", log_addr[base2+i], log_addr[base+i]);
            check("gap_same_data", log_data[base2+i], w[i]);
        end

        // Reset after the 6th byte of a 3-word frame, then reload it cleanly.
        random_words(3, w);
        make_frame(w, 0, f);
        part = f[0:5];
        pulse_start();
        send_bytes(part, 0, 0);
        RESET = 1'b1;
        #1;
        check_reset_values("midrst");
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(posedge CLK); #1;
        pulse_start();
        base = log_addr.size();
        send_bytes(f, 20, 0);
        check("midrst_load_done", load_done, 1'b1);
        check("midrst_write_count", log_addr.size() - base, 3);
        for (int i = 0; i < 3 && base + i < log_addr.size(); i++) begin
            check("midrst_addr", log_addr[base+i], 8'(i));
            check("midrst_data", log_data[base+i], w[i]);
        end

        // Reload after DONE with a single all-ones word (checksum 0x00).
        check("reload_pre_done", load_done, 1'b1);
        pulse_start();
        check("reload_cpu_reset_high", cpu_reset, 1'b1);
        check("reload_done_cleared", load_done, 1'b0);
        base = log_addr.size();
        f = '{8'h00, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
        send_bytes(f, 0, 0);
        check("reload_load_done", load_done, 1'b1);
        check("reload_write_count", log_addr.size() - base, 1);
        if (log_addr.size() - base == 1) begin
            check("reload_addr", log_addr[base], 8'd0);
            check("reload_data", log_data[base], 32'hFFFF_FFFF);
        end

        // Full-capacity frame: 256 words, last write at 255, words_loaded reaches 256.
        random_words(CAP, w2);
        make_frame(w2, 0, f);
        pulse_start();
        base = log_addr.size();
        send_bytes(f, 0, 0);
        @(posedge CLK); #1;
        check("full_load_done", load_done, 1'b1);
        check("full_words_loaded", words_loaded, 9'd256);
        check("full_write_count", log_addr.size() - base, CAP);
        if (log_addr.size() - base == CAP) begin
            check("full_last_addr", log_addr[base+CAP-1], 8'd255);
            check("full_last_data", log_data[base+CAP-1], w2[CAP-1]);
        end

        // Random frames with random gaps and occasional bad checksums.
        for (int k = 0; k < 8; k++) begin
            n   = $urandom_range(0, 12);
            bad = ($urandom_range(0, 3) == 0);
            random_words(n, w);
            make_frame(w, bad, f);
            pulse_start();
            send_bytes(f, $urandom_range(0, 60), 0);
            @(posedge CLK); #1;
            check("rand_load_done", load_done, !bad);
            check("rand_load_error", load_error, bad);
            check("rand_words_loaded", words_loaded, 9'(n));
        end

        repeat (5) @(posedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
